// File: rtl/result_packer.sv
// Packs DATA_W-bit calculator results into MEM_WORD_SIZE-bit SRAM words, lane 0 at the LSBs.
// Define RESULT_PACKER_LANE_MASK_EN to add the wr_lane_mask output (per-lane fill flags).
module result_packer #(
    parameter int DATA_W        = 32,
    parameter int MEM_WORD_SIZE = 64,
    parameter int ADDR_W        = 9,
    parameter int START_ADDR    = 0,
    parameter int END_ADDR      = 511
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    input  logic [DATA_W-1:0]        in_data,
    output logic                     in_ready,
    input  logic                     flush,
    output logic                     wr_en,
    output logic [ADDR_W-1:0]        wr_addr,
    output logic [MEM_WORD_SIZE-1:0] wr_data,
    input  logic                     wr_ready,
    output logic                     done,
`ifdef RESULT_PACKER_LANE_MASK_EN
    output logic [MEM_WORD_SIZE/DATA_W-1:0] wr_lane_mask,
`endif
    output logic                     wrapped
);

    localparam int L     = MEM_WORD_SIZE / DATA_W;
    localparam int CNT_W = $clog2(L + 1);

    localparam logic [ADDR_W-1:0] FIRST_ADDR = ADDR_W'(START_ADDR);
    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(END_ADDR);

    typedef enum logic {
        FILL,
        WRITE
    } state_e;

    state_e                   state_q,   state_d;
    logic [CNT_W-1:0]         cnt_q,     cnt_d;
    logic [MEM_WORD_SIZE-1:0] buf_q,     buf_d;
    logic [ADDR_W-1:0]        addr_q,    addr_d;
    logic                     wr_en_q,   wr_en_d;
    logic                     done_q,    done_d;
    logic                     wrapped_q, wrapped_d;

    logic accept;
    logic last_lane;

    // in_ready is forced low combinationally during reset, not just after the reset edge.
    assign in_ready  = rst_n && (state_q == FILL);
    assign accept    = in_valid && in_ready;
    assign last_lane = (cnt_q == CNT_W'(L - 1));

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        buf_d     = buf_q;
        addr_d    = addr_q;
        wr_en_d   = wr_en_q;
        done_d    = 1'b0;
        wrapped_d = wrapped_q;

        unique case (state_q)
            FILL: begin
                if (accept) begin
                    for (int k = 0; k < L; k++) begin
                        if (cnt_q == CNT_W'(k)) begin
                            buf_d[k*DATA_W +: DATA_W] = in_data;
                        end
                    end
                    cnt_d = cnt_q + 1'b1;
                end
                // A flush issued together with a result writes the word including that result.
                if ((accept && (last_lane || flush)) || (flush && (cnt_q != '0))) begin
                    state_d = WRITE;
                    wr_en_d = 1'b1;
                end
            end
            WRITE: begin
                if (wr_ready) begin
                    state_d = FILL;
                    wr_en_d = 1'b0;
                    cnt_d   = '0;
                    buf_d   = '0;
                    if (addr_q == LAST_ADDR) begin
                        addr_d    = FIRST_ADDR;
                        done_d    = 1'b1;
                        wrapped_d = 1'b1;
                    end else begin
                        addr_d = addr_q + 1'b1;
                    end
                end
            end
        endcase
    end

    // NOTE: state uses non-blocking assignments so every flop samples the pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= FILL;
            cnt_q     <= '0;
            // NOTE: the buffer is cleared on reset so a later flush never leaks stale lanes.
            buf_q     <= '0;
            addr_q    <= FIRST_ADDR;
            wr_en_q   <= 1'b0;
            done_q    <= 1'b0;
            wrapped_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            buf_q     <= buf_d;
            addr_q    <= addr_d;
            wr_en_q   <= wr_en_d;
            done_q    <= done_d;
            wrapped_q <= wrapped_d;
        end
    end

    assign wr_en   = wr_en_q;
    assign wr_addr = addr_q;
    assign wr_data = buf_q;
    assign done    = done_q;
    assign wrapped = wrapped_q;

`ifdef RESULT_PACKER_LANE_MASK_EN
    logic [L-1:0] mask_q, mask_d;

    always_comb begin
        mask_d = mask_q;
        if ((state_q == WRITE) && wr_ready) begin
            mask_d = '0;
        end else if (accept) begin
            for (int k = 0; k < L; k++) begin
                if (cnt_q == CNT_W'(k)) begin
                    mask_d[k] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mask_q <= '0;
        end else begin
            mask_q <= mask_d;
        end
    end

    assign wr_lane_mask = (rst_n && wr_en_q) ? mask_q : '0;
`endif

endmodule

// File: tb/tb_result_packer.sv
// Scoreboard bench for result_packer at default parameters (two lanes, 512 lines).
// Define RESULT_PACKER_LANE_MASK_EN to also check wr_lane_mask.
module tb_result_packer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = '0;
    logic        in_ready;
    logic        flush = 1'b0;
    logic        wr_en;
    logic [8:0]  wr_addr;
    logic [63:0] wr_data;
    logic        wr_ready = 1'b1;
    logic        done;
    logic        wrapped;
`ifdef RESULT_PACKER_LANE_MASK_EN
    logic [1:0]  wr_lane_mask;
`endif

    typedef struct {
        logic [8:0]  addr;
        logic [63:0] data;
        logic [1:0]  mask;
    } exp_t;

    exp_t       exp_q[$];
    logic [8:0] exp_addr = '0;
    int         n_compared = 0;
    int         n_mismatched = 0;
    int         done_seen = 0;

    always #5 clk = ~clk;

    result_packer dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .flush    (flush),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .wr_ready (wr_ready),
        .done     (done),
`ifdef RESULT_PACKER_LANE_MASK_EN
        .wr_lane_mask (wr_lane_mask),
`endif
        .wrapped  (wrapped)
    );

    // Scoreboard: every write handshake is popped and compared against the queued expectation.
    always @(negedge clk) begin
        if (rst_n && done) done_seen++;
        if (rst_n && wr_en && wr_ready) begin
            n_compared++;
            if (exp_q.size() == 0) begin
                n_mismatched++;
                $display("FAIL unexpected_write: addr=%0d data=%h, none expected", wr_addr, wr_data);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (wr_addr !== e.addr) begin
                    n_mismatched++;
                    $display("FAIL write_addr: got %0d expected %0d", wr_addr, e.addr);
                end
                n_compared++;
                if (wr_data !== e.data) begin
                    n_mismatched++;
                    $display("FAIL write_data: got %h expected %h", wr_data, e.data);
                end
`ifdef RESULT_PACKER_LANE_MASK_EN
                n_compared++;
                if (wr_lane_mask !== e.mask) begin
                    n_mismatched++;
                    $display("FAIL write_mask: got %b expected %b", wr_lane_mask, e.mask);
                end
`endif
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [8:0] next_addr(input logic [8:0] a);
        return (a == 9'd511) ? 9'd0 : a + 9'd1;
    endfunction

    task automatic push_exp(input logic [63:0] d, input logic [1:0] m);
        exp_t e;
        e.addr = exp_addr;
        e.data = d;
        e.mask = m;
        exp_q.push_back(e);
        exp_addr = next_addr(exp_addr);
    endtask

    // Presents one result and returns #1 after the edge on which it was accepted.
    task automatic send(input logic [31:0] d);
        int waited;
        waited = 0;
        in_valid = 1'b1;
        in_data  = d;
        @(negedge clk);
        while (!in_ready && waited < 50) begin
            waited++;
            @(negedge clk);
        end
        n_compared++;
        if (!in_ready) begin
            n_mismatched++;
            $display("FAIL send_timeout: in_ready=%b after %0d cycles, expected 1", in_ready, waited);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic write_word(input logic [31:0] d0, input logic [31:0] d1);
        push_exp({d1, d0}, 2'b11);
        send(d0);
        send(d1);
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        in_valid = 1'b1;
        in_data = 32'h12345678;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_compared++; if (wr_en !== 1'b0)    begin n_mismatched++; $display("FAIL reset_wr_en: got %b expected 0", wr_en); end
        n_compared++; if (wr_addr !== 9'd0)  begin n_mismatched++; $display("FAIL reset_wr_addr: got %0d expected 0", wr_addr); end
        n_compared++; if (wr_data !== 64'd0) begin n_mismatched++; $display("FAIL reset_wr_data: got %h expected 0", wr_data); end
        n_compared++; if (done !== 1'b0)     begin n_mismatched++; $display("FAIL reset_done: got %b expected 0", done); end
        n_compared++; if (wrapped !== 1'b0)  begin n_mismatched++; $display("FAIL reset_wrapped: got %b expected 0", wrapped); end
        n_compared++; if (in_ready !== 1'b0) begin n_mismatched++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
        @(posedge clk); #1;
        in_valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        n_compared++; if (in_ready !== 1'b1) begin n_mismatched++; $display("FAIL post_reset_in_ready: got %b expected 1", in_ready); end
        @(posedge clk); #1;
    endtask

    task automatic test_basic;
        push_exp(64'h2222222211111111, 2'b11);
        send(32'h11111111);
        send(32'h22222222);
        n_compared++; if (wr_en !== 1'b1)   begin n_mismatched++; $display("FAIL basic_wr_en: got %b expected 1", wr_en); end
        n_compared++; if (wr_addr !== 9'd0) begin n_mismatched++; $display("FAIL basic_wr_addr: got %0d expected 0", wr_addr); end
        n_compared++; if (wr_data !== 64'h2222222211111111) begin n_mismatched++; $display("FAIL basic_wr_data: got %h expected 2222222211111111", wr_data); end
        n_compared++; if (in_ready !== 1'b0) begin n_mismatched++; $display("FAIL basic_in_ready_write: got %b expected 0", in_ready); end
        @(posedge clk); #1;
        n_compared++; if (wr_en !== 1'b0)   begin n_mismatched++; $display("FAIL basic_wr_en_after: got %b expected 0", wr_en); end
        n_compared++; if (wr_addr !== 9'd1) begin n_mismatched++; $display("FAIL basic_next_addr: got %0d expected 1", wr_addr); end
    endtask

    task automatic test_backpressure;
        logic [8:0] hold_addr;
        hold_addr = exp_addr;
        wr_ready = 1'b0;
        push_exp(64'h4444444433333333, 2'b11);
        send(32'h33333333);
        send(32'h44444444);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data  = 32'hDEAD0000 + i;
            @(negedge clk);
            n_compared++; if (wr_en !== 1'b1)      begin n_mismatched++; $display("FAIL bp_wr_en[%0d]: got %b expected 1", i, wr_en); end
            n_compared++; if (wr_addr !== hold_addr) begin n_mismatched++; $display("FAIL bp_wr_addr[%0d]: got %0d expected %0d", i, wr_addr, hold_addr); end
            n_compared++; if (wr_data !== 64'h4444444433333333) begin n_mismatched++; $display("FAIL bp_wr_data[%0d]: got %h expected 4444444433333333", i, wr_data); end
            n_compared++; if (in_ready !== 1'b0)   begin n_mismatched++; $display("FAIL bp_in_ready[%0d]: got %b expected 0", i, in_ready); end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        wr_ready = 1'b1;
        @(posedge clk); #1;
        n_compared++; if (wr_en !== 1'b0)      begin n_mismatched++; $display("FAIL bp_release_wr_en: got %b expected 0", wr_en); end
        n_compared++; if (wr_addr !== exp_addr) begin n_mismatched++; $display("FAIL bp_next_addr: got %0d expected %0d", wr_addr, exp_addr); end
    endtask

    task automatic test_flush;
        push_exp(64'h00000000AAAAAAAA, 2'b01);
        send(32'hAAAAAAAA);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        n_compared++; if (wr_en !== 1'b1) begin n_mismatched++; $display("FAIL flush_wr_en: got %b expected 1", wr_en); end
        n_compared++; if (wr_data !== 64'h00000000AAAAAAAA) begin n_mismatched++; $display("FAIL flush_wr_data: got %h expected 00000000aaaaaaaa", wr_data); end
`ifdef RESULT_PACKER_LANE_MASK_EN
        n_compared++; if (wr_lane_mask !== 2'b01) begin n_mismatched++; $display("FAIL flush_mask: got %b expected 01", wr_lane_mask); end
`endif
        @(posedge clk); #1;
        // Empty-buffer flush must not produce a write.
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_compared++; if (wr_en !== 1'b0) begin n_mismatched++; $display("FAIL empty_flush_wr_en[%0d]: got %b expected 0", i, wr_en); end
        end
        n_compared++; if (wr_addr !== exp_addr) begin n_mismatched++; $display("FAIL empty_flush_addr: got %0d expected %0d", wr_addr, exp_addr); end
        @(posedge clk); #1;
        // Flush coinciding with an accepted result packs it first.
        push_exp(64'h00000000BBBBBBBB, 2'b01);
        flush = 1'b1;
        send(32'hBBBBBBBB);
        flush = 1'b0;
        n_compared++; if (wr_en !== 1'b1) begin n_mismatched++; $display("FAIL flush_accept_wr_en: got %b expected 1", wr_en); end
        n_compared++; if (wr_data !== 64'h00000000BBBBBBBB) begin n_mismatched++; $display("FAIL flush_accept_data: got %h expected 00000000bbbbbbbb", wr_data); end
        @(posedge clk); #1;
    endtask

    task automatic test_wrap;
        int n;
        int done_before;
        n_compared++; if (wrapped !== 1'b0) begin n_mismatched++; $display("FAIL wrap_early: got %b expected 0", wrapped); end
        done_before = done_seen;
        n = 512 - int'(exp_addr);
        for (int i = 0; i < n; i++) begin
            write_word($urandom, $urandom);
        end
        n_compared++; if (done !== 1'b1)    begin n_mismatched++; $display("FAIL wrap_done_pulse: got %b expected 1", done); end
        n_compared++; if (wrapped !== 1'b1) begin n_mismatched++; $display("FAIL wrap_sticky: got %b expected 1", wrapped); end
        n_compared++; if (wr_addr !== 9'd0) begin n_mismatched++; $display("FAIL wrap_addr: got %0d expected 0", wr_addr); end
        @(posedge clk); #1;
        n_compared++; if (done !== 1'b0) begin n_mismatched++; $display("FAIL wrap_done_clear: got %b expected 0", done); end
        n_compared++; if (done_seen - done_before !== 1) begin n_mismatched++; $display("FAIL wrap_done_count: got %0d expected 1", done_seen - done_before); end
        write_word(32'h0BADF00D, 32'hCAFEBABE);
        n_compared++; if (wrapped !== 1'b1) begin n_mismatched++; $display("FAIL wrap_still_sticky: got %b expected 1", wrapped); end
        n_compared++; if (done_seen - done_before !== 1) begin n_mismatched++; $display("FAIL wrap_done_once: got %0d expected 1", done_seen - done_before); end
    endtask

    task automatic test_reset_in_write;
        while (exp_addr != 9'd7) write_word($urandom, $urandom);
        wr_ready = 1'b0;
        send(32'h77777777);
        send(32'h88888888);
        n_compared++; if (wr_en !== 1'b1)   begin n_mismatched++; $display("FAIL rw_wr_en: got %b expected 1", wr_en); end
        n_compared++; if (wr_addr !== 9'd7) begin n_mismatched++; $display("FAIL rw_wr_addr: got %0d expected 7", wr_addr); end
        rst_n = 1'b0;
        @(posedge clk); #1;
        n_compared++; if (wr_en !== 1'b0)   begin n_mismatched++; $display("FAIL rw_reset_wr_en: got %b expected 0", wr_en); end
        n_compared++; if (wr_addr !== 9'd0) begin n_mismatched++; $display("FAIL rw_reset_addr: got %0d expected 0", wr_addr); end
        n_compared++; if (wrapped !== 1'b0) begin n_mismatched++; $display("FAIL rw_reset_wrapped: got %b expected 0", wrapped); end
        rst_n = 1'b1;
        wr_ready = 1'b1;
        exp_addr = 9'd0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_compared++; if (wr_en !== 1'b0) begin n_mismatched++; $display("FAIL rw_discard[%0d]: got %b expected 0", i, wr_en); end
        end
        @(posedge clk); #1;
        write_word(32'h55555555, 32'h66666666);
        n_compared++; if (wr_addr !== 9'd1) begin n_mismatched++; $display("FAIL rw_after_addr: got %0d expected 1", wr_addr); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_flush();
        test_wrap();
        test_reset_in_write();
        repeat (3) @(posedge clk);
        n_compared++;
        if (exp_q.size() != 0) begin
            n_mismatched++;
            $display("FAIL scoreboard_drain: %0d writes outstanding, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/result_packer.md
RESULT_PACKER -- requirements
Module: result_packer

Interface
REQ-001 Parameter DATA_W, default 32, width of one calculator result.
REQ-002 Parameter MEM_WORD_SIZE, default 64, SRAM word width; SHALL be an integer multiple of DATA_W. L = MEM_WORD_SIZE/DATA_W lanes.
REQ-003 Parameter ADDR_W, default 9, SRAM address width (512 lines).
REQ-004 Parameter START_ADDR, default 0, first write address.
REQ-005 Parameter END_ADDR, default 511, last write address; SHALL be at least START_ADDR.
REQ-006 clk  in  1  single clock; all state updates on rising edge.
REQ-007 rst_n  in  1  reset, synchronous and active-low.
REQ-008 in_valid  in  1  result present on in_data.
REQ-009 in_data  in  DATA_W  result to pack.
REQ-010 in_ready  out  1  packer accepts a result this cycle.
REQ-011 flush  in  1  request to write a partially filled word.
REQ-012 wr_en  out  1  SRAM write request.
REQ-013 wr_addr  out  ADDR_W  SRAM write address.
REQ-014 wr_data  out  MEM_WORD_SIZE  packed word.
REQ-015 wr_ready  in  1  SRAM accepts the write this cycle.
REQ-016 done  out  1  one-cycle pulse when the END_ADDR write is accepted.
REQ-017 wrapped  out  1  sticky; set when the address wraps from END_ADDR to START_ADDR.

Function
REQ-018 States FILL and WRITE; in_ready SHALL be 1 exactly when state is FILL and rst_n is 1.
REQ-019 A result SHALL be accepted when in_valid and in_ready are both 1; result k of a word SHALL occupy wr_data bits [k*DATA_W +: DATA_W], with lane 0 at the LSBs.
REQ-020 Acceptance of lane L-1 in cycle N SHALL put the block in WRITE with wr_en=1 in cycle N+1.
REQ-021 In WRITE, wr_en, wr_addr and wr_data SHALL hold stable until wr_en and wr_ready are both 1.
REQ-022 On a write handshake, the lane count and buffer SHALL clear and the state SHALL return to FILL; wr_addr SHALL then increment, or load START_ADDR if it equalled END_ADDR.
REQ-023 A handshake at END_ADDR SHALL pulse done for the following cycle and SHALL set wrapped.
REQ-024 flush in FILL with a lane count above 0 SHALL enter WRITE the next cycle; unfilled lanes SHALL be zero.
REQ-025 flush with a lane count of 0 and no accepted result SHALL be ignored; flush in WRITE SHALL be ignored.
REQ-026 If flush and an accepted result occur in the same cycle, the result SHALL be packed first and the word SHALL then be written.
REQ-027 When L=1, every accepted result SHALL produce a write on the next cycle.

Reset
REQ-028 While rst_n=0 at a clock edge: state goes to FILL, the lane count to 0, the buffer to 0, wr_addr to START_ADDR, and wr_en, done and wrapped to 0; in_ready SHALL be 0.
REQ-029 Reset during WRITE SHALL discard the pending word without asserting wr_en again.

Configuration
REQ-030 With macro RESULT_PACKER_LANE_MASK_EN defined, an output wr_lane_mask [L-1:0] SHALL be present, with bit k set when lane k holds an accepted result. It SHALL be valid while wr_en=1 and SHALL be 0 otherwise and in reset.
REQ-031 Without RESULT_PACKER_LANE_MASK_EN, the wr_lane_mask port SHALL be absent and all other behaviour SHALL be unchanged.

Verification (defaults, L=2)
REQ-032 Accept 0x11111111 and then 0x22222222 with wr_ready=1 -> the next cycle shows wr_en=1, wr_addr=0 and wr_data=0x2222222211111111; the address after that is 1.
REQ-033 Hold wr_ready=0 for 5 cycles during WRITE -> wr_en, wr_addr and wr_data stay stable, in_ready=0, and in_valid pulses are not accepted.
REQ-034 Accept 0xAAAAAAAA, then flush -> wr_data=0x00000000AAAAAAAA and wr_lane_mask=2'b01 (mask enabled); flush with an empty buffer produces no write.
REQ-035 Write 512 words -> done pulses once after the write at address 511, wrapped=1, and the next write uses address 0.
REQ-036 Assert rst_n=0 with wr_en=1 at address 7 -> the next cycle shows wr_en=0 and wr_addr=0, and the pending word is never written.
